// File: rtl/usb_rx_packet_ctrl_pkg.sv
// Shared types, default parameters and the PID integrity check for the USB RX packet controller.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StToken,
        StEopWait,
        StData,
        StDone,
        StError
    } rx_state_t;

    localparam logic [7:0]  SYNC_PATTERN_DEFAULT   = 8'h54;
    localparam int unsigned MAX_PAYLOAD_DEFAULT    = 64;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;

    // A PID byte carries its own check nibble: the upper nibble is the inverse of the lower one.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_packet_ctrl_if.sv
// Byte-assembler/FIFO side signals of the RX packet controller.
interface usb_rx_packet_ctrl_if;
    logic       packet_type;
    logic       start;
    logic       byte_rcvd;
    logic [7:0] rcv_byte;
    logic       eop;
    logic       line_error;
    logic       clear;
    logic       rcving;
    logic [7:0] rx_data;
    logic       write_enable;
    logic       rcv_error;
    logic       rx_done;
    logic [3:0] pid;

    modport master (
        output packet_type, start, byte_rcvd, rcv_byte, eop, line_error,
        input  clear, rcving, rx_data, write_enable, rcv_error, rx_done, pid
    );

    modport slave (
        input  packet_type, start, byte_rcvd, rcv_byte, eop, line_error,
        output clear, rcving, rx_data, write_enable, rcv_error, rx_done, pid
    );
endinterface

// File: rtl/usb_rx_timeout_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle whose count would
// reach the limit.
module usb_rx_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Expiry is combinational so the error is taken on the very edge the count reaches the limit.
    assign o_expired = i_count_en && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, cleared on every strobe and whenever the controller is not receiving.
    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_count_en) begin
            r_count <= '0;
        end else if (r_count != CW'(TIMEOUT_CYCLES)) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// Packet-level RX controller: SYNC/PID checking, token/data body sequencing, CRC16 stripping
// through a 2-deep hold pipe, and FIFO write / error / done signalling.
module usb_rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_PATTERN   = SYNC_PATTERN_DEFAULT,
    parameter int unsigned MAX_PAYLOAD    = MAX_PAYLOAD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    usb_rx_packet_ctrl_if.slave bus
);
    localparam int unsigned    PCW       = $clog2(MAX_PAYLOAD + 3);
    // Body bytes = payload + 2 CRC bytes; one more than this is an oversize packet.
    localparam logic [PCW-1:0] PAY_LIMIT = PCW'(MAX_PAYLOAD + 2);

    rx_state_t      r_state, w_state_next;
    logic [7:0]     r_hold0, w_hold0;        // oldest held byte
    logic [7:0]     r_hold1, w_hold1;
    logic [1:0]     r_hold_cnt, w_hold_cnt;
    logic [PCW-1:0] r_body_cnt, w_body_cnt;
    logic           r_tok_second, w_tok_second;
    logic           r_clear, w_clear;
    logic           r_rcving, w_rcving;
    logic [7:0]     r_rx_data, w_rx_data;
    logic           r_write, w_write;
    logic           r_rcv_error, w_rcv_error;
    logic           r_rx_done, w_rx_done;
    logic [3:0]     r_pid, w_pid;
    logic           w_fault, w_close, w_expired, w_count_en;

    assign w_count_en = r_state inside {StSync, StPid, StToken, StEopWait, StData};

    usb_rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (bus.byte_rcvd),
        .i_count_en(w_count_en),
        .o_expired (w_expired)
    );

    // Next-state and next-output decode; aborts are applied last so they override any action.
    always_comb begin
        w_state_next = r_state;
        w_hold0      = r_hold0;
        w_hold1      = r_hold1;
        w_hold_cnt   = r_hold_cnt;
        w_body_cnt   = r_body_cnt;
        w_tok_second = r_tok_second;
        w_clear      = 1'b0;
        w_write      = 1'b0;
        w_rx_done    = 1'b0;
        w_rx_data    = r_rx_data;
        w_rcving     = r_rcving;
        w_rcv_error  = r_rcv_error;
        w_pid        = r_pid;
        w_fault      = 1'b0;
        w_close      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StSync;
                    w_clear      = 1'b1;
                    w_rcv_error  = 1'b0;
                    w_rcving     = 1'b1;
                    w_hold_cnt   = 2'd0;
                    w_body_cnt   = '0;
                    w_tok_second = 1'b0;
                end
            end
            StSync: begin
                if (bus.byte_rcvd) begin
                    if (bus.rcv_byte == SYNC_PATTERN) w_state_next = StPid;
                    else                              w_fault      = 1'b1;
                end else if (bus.eop) begin
                    w_fault = 1'b1;
                end
            end
            StPid: begin
                if (bus.byte_rcvd) begin
                    if (pid_ok(bus.rcv_byte)) begin
                        w_pid        = bus.rcv_byte[3:0];
                        w_state_next = bus.packet_type ? StData : StToken;
                    end else begin
                        w_fault = 1'b1;
                    end
                end else if (bus.eop) begin
                    w_fault = 1'b1;
                end
            end
            StToken: begin
                if (bus.byte_rcvd) begin
                    w_write      = 1'b1;
                    w_rx_data    = bus.rcv_byte;
                    w_tok_second = 1'b1;
                    if (r_tok_second) w_state_next = StEopWait;
                end else if (bus.eop) begin
                    w_fault = 1'b1;
                end
            end
            StEopWait: begin
                if (bus.byte_rcvd)  w_fault = 1'b1;
                else if (bus.eop)   w_close = 1'b1;
            end
            StData: begin
                if (bus.byte_rcvd) begin
                    if (r_body_cnt >= PAY_LIMIT) begin
                        w_fault = 1'b1;
                    end else begin
                        w_body_cnt = r_body_cnt + 1'b1;
                        // Only a byte with two younger bytes behind it is known not to be CRC.
                        if (r_hold_cnt == 2'd2) begin
                            w_write   = 1'b1;
                            w_rx_data = r_hold0;
                            w_hold0   = r_hold1;
                            w_hold1   = bus.rcv_byte;
                        end else if (r_hold_cnt == 2'd1) begin
                            w_hold1    = bus.rcv_byte;
                            w_hold_cnt = 2'd2;
                        end else begin
                            w_hold0    = bus.rcv_byte;
                            w_hold_cnt = 2'd1;
                        end
                    end
                end else if (bus.eop) begin
                    if (r_hold_cnt == 2'd2) w_close = 1'b1;
                    else                    w_fault = 1'b1;
                end
            end
            StDone:  w_state_next = StIdle;
            StError: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase

        if (r_state != StIdle && (bus.line_error || (bus.byte_rcvd && bus.eop) || w_expired)) begin
            w_fault = 1'b1;
        end

        if (w_fault) begin
            w_state_next = StError;
            w_write      = 1'b0;
            w_rx_data    = r_rx_data;
            w_pid        = r_pid;
            w_hold_cnt   = 2'd0;
            w_rcv_error  = 1'b1;
            w_rcving     = 1'b0;
        end else if (w_close) begin
            w_state_next = StDone;
            w_rx_done    = 1'b1;
            w_hold_cnt   = 2'd0;
            w_rcving     = 1'b0;
        end
    end

    // State, hold pipe and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_hold0      <= '0;
            r_hold1      <= '0;
            r_hold_cnt   <= '0;
            r_body_cnt   <= '0;
            r_tok_second <= 1'b0;
            r_clear      <= 1'b0;
            r_rcving     <= 1'b0;
            r_rx_data    <= '0;
            r_write      <= 1'b0;
            r_rcv_error  <= 1'b0;
            r_rx_done    <= 1'b0;
            r_pid        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_hold0      <= w_hold0;
            r_hold1      <= w_hold1;
            r_hold_cnt   <= w_hold_cnt;
            r_body_cnt   <= w_body_cnt;
            r_tok_second <= w_tok_second;
            r_clear      <= w_clear;
            r_rcving     <= w_rcving;
            r_rx_data    <= w_rx_data;
            r_write      <= w_write;
            r_rcv_error  <= w_rcv_error;
            r_rx_done    <= w_rx_done;
            r_pid        <= w_pid;
        end
    end

    assign bus.clear        = r_clear;
    assign bus.rcving       = r_rcving;
    assign bus.rx_data      = r_rx_data;
    assign bus.write_enable = r_write;
    assign bus.rcv_error    = r_rcv_error;
    assign bus.rx_done      = r_rx_done;
    assign bus.pid          = r_pid;
endmodule
